// File: rtl/spin_readout_pkg.sv
// Shared definitions for the spin readout stage: FSM encoding and width helpers.
package spin_readout_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  // Mismatch counters must hold the full window count (0..WINDOW).
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

  // Timer counts 0..max(SETTLE_CYCLES, WINDOW)-1; keep at least one bit.
  function automatic int timer_width(input int settle, input int window);
    int m;
    m = (settle > window) ? settle : window;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spin_readout_osc_synchronizer.sv
// Multi-flop synchroniser for the asynchronous oscillator outputs; every bit
// sees the same latency so relative phase between bits is preserved.
module osc_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) stage_reg[k] <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int k = 1; k < STAGES; k++) stage_reg[k] <= stage_reg[k-1];
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/spin_readout.sv
// Sequences one anneal run of the oscillator matrix and decides each spin
// from its phase relative to oscillator 0 by majority over a sample window.
module spin_readout
  import spin_readout_pkg::*;
#(
  parameter int N             = 3,
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW        = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] osc_in,
  output logic         core_rstn,
  output logic         busy,
  output logic         spins_valid,
  input  logic         spins_ready,
  output logic [N-1:0] spins
);

  localparam int CW = cnt_width(WINDOW);
  localparam int TW = timer_width(SETTLE_CYCLES, WINDOW);

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic          core_rstn_reg;
  logic          busy_reg;
  logic          valid_reg;
  logic [N-1:0]  spins_reg;
  logic [CW-1:0] cnt_reg [1:N-1];

  logic [N-1:0]  s;
  logic [CW-1:0] fcnt [1:N-1];
  logic [N-1:0]  spin_next;

  osc_synchronizer #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (osc_in),
    .q    (s)
  );

  // Per-lane count including the current sample; on the last window edge this
  // is the final tally, so the decision needs no extra cycle.
  assign spin_next[0] = 1'b0;
  for (genvar gi = 1; gi < N; gi++) begin : g_lane
    assign fcnt[gi]      = cnt_reg[gi] + CW'(s[gi] ^ s[0]);
    assign spin_next[gi] = (fcnt[gi] > CW'(WINDOW / 2));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      core_rstn_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      spins_reg     <= '0;
      for (int i = 1; i < N; i++) cnt_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= SETTLE;
            core_rstn_reg <= 1'b1;
            busy_reg      <= 1'b1;
            timer_reg     <= '0;
          end
        end
        SETTLE: begin
          if (timer_reg == TW'(SETTLE_CYCLES - 1)) begin
            state_reg <= SAMPLE;
            timer_reg <= '0;
            for (int i = 1; i < N; i++) cnt_reg[i] <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        SAMPLE: begin
          for (int i = 1; i < N; i++) cnt_reg[i] <= fcnt[i];
          if (timer_reg == TW'(WINDOW - 1)) begin
            state_reg <= DONE;
            spins_reg <= spin_next;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        DONE: begin
          if (spins_ready) begin
            state_reg     <= IDLE;
            valid_reg     <= 1'b0;
            core_rstn_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign core_rstn   = core_rstn_reg;
  assign busy        = busy_reg;
  assign spins_valid = valid_reg;
  assign spins       = spins_reg;

endmodule

// File: tb/tb_spin_readout.sv
// Directed bench for spin_readout: N=4, SETTLE_CYCLES=4, WINDOW=16, square-wave
// oscillators of period 4 with per-oscillator phase offsets.
module tb_spin_readout;

  localparam int N  = 4;
  localparam int SC = 4;
  localparam int WN = 16;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [N-1:0] osc_in;
  logic         core_rstn;
  logic         busy;
  logic         spins_valid;
  logic         spins_ready;
  logic [N-1:0] spins;

  int errors = 0;
  int checks = 0;
  int off [N];
  int ph;

  spin_readout #(
    .N             (N),
    .SETTLE_CYCLES (SC),
    .WINDOW        (WN),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .osc_in      (osc_in),
    .core_rstn   (core_rstn),
    .busy        (busy),
    .spins_valid (spins_valid),
    .spins_ready (spins_ready),
    .spins       (spins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator i is high for phase (ph+off[i]) mod 4 in {0,1}.
  initial begin
    ph = 0;
    osc_in = '0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      for (int i = 0; i < N; i++) osc_in[i] = (((ph + off[i]) % 4) < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_off(input int o0, input int o1, input int o2, input int o3);
    off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
  endtask

  task automatic accept(input string tag);
    chk({tag, "_idle_core_rstn"}, 32'(core_rstn), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_core_rstn_up"}, 32'(core_rstn), 32'd1);
    chk({tag, "_busy_up"}, 32'(busy), 32'd1);
  endtask

  // Counts edges until spins_valid; start is pulsed before edge poke_at+1.
  task automatic wait_valid(input int poke_at, output int edges, output int busy_n);
    edges  = 0;
    busy_n = busy ? 1 : 0;
    while (!spins_valid && edges < 100) begin
      start = (edges == poke_at);
      tick();
      start = 1'b0;
      edges++;
      if (busy) busy_n++;
    end
  endtask

  task automatic run(input string tag, input int poke_at, input logic [3:0] exp_spins);
    int edges, busy_n;
    accept(tag);
    wait_valid(poke_at, edges, busy_n);
    chk({tag, "_latency"}, 32'(edges), 32'(SC + WN));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(SC + WN));
    chk({tag, "_spins"}, 32'(spins), 32'(exp_spins));
  endtask

  initial begin
    int vcount;
    logic [3:0] held;
    rstn = 1'b0;
    start = 1'b0;
    spins_ready = 1'b0;
    set_off(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_core_rstn", 32'(core_rstn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(spins_valid), 32'd0);
    chk("rst_spins", 32'(spins), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // All in phase, ready held high.
    spins_ready = 1'b1;
    run("inphase", -1, 4'b0000);
    tick();
    chk("inphase_valid_drop", 32'(spins_valid), 32'd0);
    chk("inphase_core_rstn_drop", 32'(core_rstn), 32'd0);
    chk("inphase_busy_idle", 32'(busy), 32'd0);

    // Oscillator 2 inverted; a start during SETTLE must be ignored.
    set_off(0, 0, 2, 0);
    run("inv2", 2, 4'b0100);
    tick();
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (spins_valid) vcount++;
    end
    chk("inv2_no_extra_valid", 32'(vcount), 32'd0);
    chk("inv2_idle_busy", 32'(busy), 32'd0);

    // Oscillators 1 and 3 inverted, consumer stalls for 10 cycles.
    set_off(0, 2, 0, 2);
    spins_ready = 1'b0;
    run("inv13", -1, 4'b1010);
    held = spins;
    for (int k = 0; k < 10; k++) begin
      start = (k == 5);
      tick();
      start = 1'b0;
      chk($sformatf("stall%0d_valid", k), 32'(spins_valid), 32'd1);
      chk($sformatf("stall%0d_spins", k), 32'(spins), 32'(held));
      chk($sformatf("stall%0d_core_rstn", k), 32'(core_rstn), 32'd1);
    end

    // Handshake edge with start high: not accepted; next edge accepts.
    set_off(0, 0, 0, 1);
    spins_ready = 1'b1;
    start = 1'b1;
    tick();
    chk("hs_valid_drop", 32'(spins_valid), 32'd0);
    chk("hs_core_rstn_drop", 32'(core_rstn), 32'd0);
    chk("hs_start_not_taken", 32'(busy), 32'd0);
    chk("hs_spins_kept", 32'(spins), 32'b1010);
    tick();
    start = 1'b0;
    chk("hs_next_accept_busy", 32'(busy), 32'd1);
    chk("hs_next_accept_core", 32'(core_rstn), 32'd1);
    begin
      int edges, busy_n;
      wait_valid(-1, edges, busy_n);
      chk("quarter_latency", 32'(edges), 32'(SC + WN));
      chk("quarter_tie_spins", 32'(spins), 32'b0000);
    end
    tick();

    // Half-period offset: 16 of 16 mismatches.
    set_off(0, 0, 0, 2);
    run("half3", -1, 4'b1000);
    tick();

    // Reset asserted mid-SAMPLE: outputs clear without a clock edge.
    set_off(0, 2, 0, 2);
    accept("rstmid");
    repeat (8) tick();
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    chk("rstmid_spins_before", 32'(spins), 32'b1000);
    rstn = 1'b0;
    #1;
    chk("rstmid_core_rstn", 32'(core_rstn), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_valid", 32'(spins_valid), 32'd0);
    chk("rstmid_spins", 32'(spins), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rstmid_idle_after", 32'(busy), 32'd0);

    set_off(0, 2, 2, 0);
    run("post_rst", -1, 4'b0110);
    tick();
    chk("post_rst_idle", 32'(core_rstn), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spin_readout.md
Name: spin_readout

Overview:
- Downstream stage of the coupled-oscillator core matrix. Sequences one anneal run of the matrix and decides the spin of each oscillator from its phase relative to oscillator 0.
- Drives the matrix reset (core_rstn) and synchronises its N asynchronous oscillator outputs into the clock domain.
- After a settle period, counts phase mismatches over a fixed window and presents an N-bit spin vector on a valid/ready handshake.

Parameters:
- N, 3: number of oscillators; matches the matrix N; minimum 2.
- SETTLE_CYCLES, 64: cycles with core_rstn high before sampling starts; minimum 1.
- WINDOW, 32: number of sample cycles; minimum 1.
- SYNC_STAGES, 2: flops per synchroniser; minimum 2.

Ports:
- clk  input  1  sampling clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request one run; sampled only in IDLE.
- osc_in  input  N  oscillator outputs from the matrix (outputs_ver); asynchronous to clk.
- core_rstn  output  1  reset to the matrix; low holds the oscillators stopped.
- busy  output  1  high in SETTLE and SAMPLE.
- spins_valid  output  1  spin vector available.
- spins_ready  input  1  consumer accepts the spin vector.
- spins  output  N  bit i = 1 when oscillator i is anti-phase to oscillator 0; bit 0 is always 0.

Behaviour:
- Reset (async, rstn low): state IDLE, core_rstn=0, busy=0, spins_valid=0, spins=0, counters=0, synchroniser flops=0.
- Synchronisers: every osc_in bit passes through SYNC_STAGES flops; s[i] is the last stage. All bits see equal latency, so XOR phase is preserved.
- FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - core_rstn=0.
  - When start=1 at an edge: go to SETTLE, core_rstn=1, timer=0.
  - When start=0: stay in IDLE.
- SETTLE:
  - timer increments each edge.
  - At the edge where timer==SETTLE_CYCLES-1: go to SAMPLE, timer=0, all mismatch counters cleared.
- SAMPLE:
  - At each edge, for i in 1..N-1: cnt[i] += (s[i] ^ s[0]).
  - At the edge where timer==WINDOW-1, the final count is fcnt[i] = cnt[i] + (s[i]^s[0]), including that last sample.
  - spins[i] <= (fcnt[i] > WINDOW/2), using integer floor and strict compare. A tie resolves to 0.
  - spins[0] <= 0.
  - Same edge: go to DONE, spins_valid=1.
- Counter width: $clog2(WINDOW+1); counters never overflow.
- DONE:
  - core_rstn stays 1; spins and spins_valid are held stable.
  - When spins_valid && spins_ready at an edge: go to IDLE, spins_valid=0, core_rstn=0. spins keeps its last value.
- Latency: spins_valid rises exactly SETTLE_CYCLES+WINDOW edges after the edge that accepted start.
- start outside IDLE is ignored. There is no queued request; start must be presented again once in IDLE.
- A handshake and start in the same cycle: start is not accepted (the state was DONE). The earliest accept is the following edge.
- spins_ready outside DONE is ignored.
- Reset asserted mid-run (any state): immediate return to the reset values. core_rstn drops asynchronously and the partial result is discarded.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams ST_IDLE/ST_SETTLE/ST_SAMPLE/ST_DONE), and the counter-width and timer-width localparam functions.
- Timer width: $clog2(max(SETTLE_CYCLES, WINDOW)).
- Sub-module osc_synchronizer: parameters WIDTH, STAGES; ports clk, rstn, d, q. Instantiated once with WIDTH=N.

Test Plan (N=4, SETTLE_CYCLES=4, WINDOW=16, SYNC_STAGES=2; bench drives osc_in as clk-aligned square waves of period 4):
- All four oscillators in phase; pulse start; spins_ready=1 -> core_rstn rises 1 edge after start, busy high 20 cycles, spins_valid pulses 20 edges after accept, spins=4'b0000; back to IDLE with core_rstn=0.
- osc_in[2] inverted, others in phase -> spins=4'b0100; osc_in[1] and osc_in[3] inverted -> spins=4'b1010.
- osc_in[3] offset a quarter period (8 of 16 mismatches) -> spins[3]=0 (tie). Half-period offset (16 of 16) -> spins[3]=1.
- spins_ready held 0 for 10 cycles after valid -> spins_valid and spins stable all 10 cycles, core_rstn stays 1; ready=1 -> one transfer, then IDLE.
- start pulsed again during SETTLE and during DONE -> ignored; exactly one valid per accepted start; start in the handshake cycle is not accepted.
- rstn pulsed low during SAMPLE -> core_rstn, busy, spins_valid go 0 without waiting for a clk edge, spins=0, state IDLE; a following run yields a correct result.
